// File: rtl/repeat_int_sched.sv
// rtl/repeat_int_sched.sv - two-requester round-robin scheduler for a shared repeat-int stream generator.
// Define REPEAT_SCHED_FIXED_PRIO_EN to make requester 0 always win simultaneous requests.
module repeat_int_sched #(
  parameter int N = 8,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [N-1:0] r0_data,
  input  logic [C-1:0] r0_count,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [N-1:0] r1_data,
  input  logic [C-1:0] r1_count,
  output logic         gen_valid,
  input  logic         gen_ready,
  output logic [N-1:0] gen_data,
  input  logic [N-1:0] gen_s,
  input  logic         gen_s_valid,
  output logic         gen_s_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_id,
  output logic         out_last
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t         state_q, state_d;
  logic           prio_q, prio_d;
  logic           owner_q, owner_d;
  logic [C-1:0]   rem_q, rem_d;
  logic [N-1:0]   value_q, value_d;
  logic           sel;
  logic [C-1:0]   sel_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      rem_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    rem_d       = rem_q;
    value_d     = value_q;
    sel         = 1'b0;
    sel_count   = '0;
    r0_ready    = 1'b0;
    r1_ready    = 1'b0;
    gen_valid   = 1'b0;
    gen_data    = '0;
    gen_s_ready = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_id      = 1'b0;
    out_last    = 1'b0;

    unique case (state_q)
      IDLE: begin
`ifdef REPEAT_SCHED_FIXED_PRIO_EN
        sel = !r0_valid;
`else
        sel = (r0_valid && r1_valid) ? prio_q : r1_valid;
`endif
        sel_count = sel ? r1_count : r0_count;
        // Grant is combinational, so it must be masked while reset is held.
        if (!rst && (r0_valid || r1_valid)) begin
          r0_ready = !sel;
          r1_ready = sel;
          value_d  = sel ? r1_data : r0_data;
          owner_d  = sel;
          if (sel_count == '0) begin
            prio_d = !sel;
          end else begin
            rem_d   = sel_count;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        gen_valid = 1'b1;
        gen_data  = value_q;
        if (gen_ready) state_d = RUN;
      end
      RUN: begin
        out_valid   = gen_s_valid;
        gen_s_ready = out_ready;
        out_data    = gen_s;
        out_id      = owner_q;
        out_last    = (rem_q == C'(1));
        if (gen_s_valid && out_ready) begin
          rem_d = rem_q - C'(1);
          if (rem_q == C'(1)) begin
            state_d = IDLE;
            prio_d  = !owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_repeat_int_sched.sv
// tb/tb_repeat_int_sched.sv - directed self-checking bench for repeat_int_sched.
module tb_repeat_int_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic       r0_valid, r0_ready, r1_valid, r1_ready;
  logic [7:0] r0_data, r0_count, r1_data, r1_count;
  logic       gen_valid, gen_ready;
  logic [7:0] gen_data;
  logic [7:0] gen_s = 8'd0;
  logic       gen_s_valid = 1'b0;
  logic       gen_s_ready;
  logic       out_valid, out_ready, out_id, out_last;
  logic [7:0] out_data;
  int         n_checks = 0;
  int         n_errors = 0;

  repeat_int_sched #(.N(8), .C(8)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data), .r0_count(r0_count),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data), .r1_count(r1_count),
    .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_data(gen_data),
    .gen_s(gen_s), .gen_s_valid(gen_s_valid), .gen_s_ready(gen_s_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Generator model: repeats the last loaded value forever.
  always @(posedge clk) begin
    if (gen_valid && gen_ready) begin
      gen_s       <= gen_data;
      gen_s_valid <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic collect(input int take, input int total, input logic [7:0] d, input logic id,
                         input bit bp, output int first);
    int got = 0;
    int cyc = 0;
    first = -1;
    while (got < take && cyc < 2000) begin
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        check("gs_ready", gen_s_ready, out_ready);
        check("out_last", out_last, (got + 1 == total));
        if (out_ready) begin
          got++;
          check("out_data", out_data, d);
          check("out_id", out_id, id);
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("n_xfer", got, take);
    out_ready = 1'b1;
    #1;
    if (take == total) check("idle_ov", out_valid, 0);
  endtask

  task automatic serve(input logic who, input logic [7:0] d, input int cnt, input bit bp,
                       input int take, input bit keep, input logic [7:0] nd, input logic [7:0] nc);
    int f;
    #1;
    check("grant0", r0_ready, (who == 1'b0));
    check("grant1", r1_ready, (who == 1'b1));
    @(negedge clk);
    if (who == 1'b0) begin
      if (keep) begin r0_data = nd; r0_count = nc; end else r0_valid = 1'b0;
    end else begin
      if (keep) begin r1_data = nd; r1_count = nc; end else r1_valid = 1'b0;
    end
    #1;
    check("gen_valid", gen_valid, 1);
    check("gen_data", gen_data, d);
    collect(take, cnt, d, who, bp, f);
    check("latency", f, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_r0rdy"}, r0_ready, 0);
    check({tag, "_r1rdy"}, r1_ready, 0);
    check({tag, "_gv"}, gen_valid, 0);
    check({tag, "_gd"}, gen_data, 0);
    check({tag, "_gsr"}, gen_s_ready, 0);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_od"}, out_data, 0);
    check({tag, "_oid"}, out_id, 0);
    check({tag, "_olast"}, out_last, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; gen_ready = 1'b1; out_ready = 1'b0;
    r0_valid = 1'b1; r0_data = 8'd42; r0_count = 8'd3;
    r1_valid = 1'b0; r1_data = 8'd0;  r1_count = 8'd0;
    @(negedge clk); #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single request
    serve(1'b0, 8'd42, 3, 1'b0, 3, 1'b0, 8'd0, 8'd0);

    // Simultaneous requests; r0 re-requests while r1 is still pending
    reset_dut();
    r0_valid = 1'b1; r0_data = 8'd7; r0_count = 8'd2;
    r1_valid = 1'b1; r1_data = 8'd9; r1_count = 8'd2;
    serve(1'b0, 8'd7, 2, 1'b0, 2, 1'b1, 8'd11, 8'd1);
`ifdef REPEAT_SCHED_FIXED_PRIO_EN
    serve(1'b0, 8'd11, 1, 1'b0, 1, 1'b0, 8'd0, 8'd0);
    serve(1'b1, 8'd9, 2, 1'b0, 2, 1'b0, 8'd0, 8'd0);
`else
    serve(1'b1, 8'd9, 2, 1'b0, 2, 1'b0, 8'd0, 8'd0);
    serve(1'b0, 8'd11, 1, 1'b0, 1, 1'b0, 8'd0, 8'd0);
`endif

    // Backpressure
    r1_valid = 1'b1; r1_data = 8'd5; r1_count = 8'd4;
    serve(1'b1, 8'd5, 4, 1'b1, 4, 1'b0, 8'd0, 8'd0);

    // Zero count with r1 pending
    r0_valid = 1'b1; r0_data = 8'd99; r0_count = 8'd0;
    r1_valid = 1'b1; r1_data = 8'd3;  r1_count = 8'd1;
    #1;
    check("zc_r0rdy", r0_ready, 1);
    check("zc_r1rdy", r1_ready, 0);
    @(negedge clk);
    r0_valid = 1'b0;
    #1;
    check("zc_gv", gen_valid, 0);
    check("zc_ov", out_valid, 0);
    serve(1'b1, 8'd3, 1, 1'b0, 1, 1'b0, 8'd0, 8'd0);

    // Reset in the middle of RUN
    r0_valid = 1'b1; r0_data = 8'd20; r0_count = 8'd10;
    serve(1'b0, 8'd20, 10, 1'b0, 3, 1'b0, 8'd0, 8'd0);
    r1_valid = 1'b1; r1_data = 8'd8; r1_count = 8'd1;
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    serve(1'b1, 8'd8, 1, 1'b0, 1, 1'b0, 8'd0, 8'd0);

    // Maximum count
    r0_valid = 1'b1; r0_data = 8'hA5; r0_count = 8'd255;
    serve(1'b0, 8'hA5, 255, 1'b0, 255, 1'b0, 8'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/repeat_int_sched.md
Name: repeat_int_sched

Overview:
- Round-robin scheduler that shares one repeat-int stream generator (int in, repeating stream out, sync handshake) between two requesters.
- Each requester submits a value and an element count.
- The scheduler loads the value into the generator, then forwards exactly that many stream elements to a single tagged output.
- It then releases the generator to the other requester.

Parameters:
- N, 8 (`intN`): data width of values and stream elements.
- C, 8: width of the element-count field.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- r0_valid  in  1  requester 0 request valid.
- r0_ready  out  1  requester 0 request accepted (single-cycle pulse).
- r0_data  in  N  requester 0 value to repeat.
- r0_count  in  C  requester 0 number of elements wanted.
- r1_valid, r1_ready, r1_data, r1_count: same as r0_*, for requester 1.
- gen_valid  out  1  generator input valid (load strobe).
- gen_ready  in  1  generator input ready.
- gen_data  out  N  value loaded into the generator.
- gen_s  in  N  generator stream element.
- gen_s_valid  in  1  generator stream valid.
- gen_s_ready  out  1  generator stream ready.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream ready.
- out_data  out  N  output element.
- out_id  out  1  requester that owns the current element.
- out_last  out  1  current element is the final one of the request.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, prio pointer=0, remaining=0, captured value=0, owner=0.
  - All outputs are 0.
  - A reset in LOAD or RUN abandons the transfer immediately. No out_last is emitted.
- Handshake rule: a transfer occurs on any posedge clk where valid && ready.
- States: IDLE, LOAD, RUN.
- IDLE:
  - Requester selection: if exactly one rX_valid is high, select that requester. If both are high, select the one named by the prio pointer.
  - Combinational grant: rX_ready=1 for the selected requester in the same cycle.
  - On that edge, capture rX_data, rX_count and owner.
  - count==0: zero-length request. It is consumed, there is no generator load or output, state stays IDLE, and the prio pointer flips to !owner.
  - count>0: remaining=count, go to LOAD.
- LOAD:
  - gen_valid=1, gen_data=captured value.
  - On the gen_ready transfer, go to RUN.
  - rX_ready=0 for both requesters.
- RUN:
  - out_valid=gen_s_valid, gen_s_ready=out_ready.
  - out_data=gen_s, out_id=owner.
  - out_last=(remaining==1).
  - Each output transfer decrements remaining.
  - On the transfer with remaining==1, go to IDLE and set the prio pointer to !owner.
  - Outside RUN: gen_s_ready=0 and out_valid=0, so stale generator elements are held and never forwarded.
- Latency: acceptance edge -> earliest gen_valid 1 cycle later -> earliest out_valid 1 cycle after the gen transfer (generator latency permitting).
- Back-to-back: after the last element the scheduler is in IDLE next cycle, so requests can be granted every (count+2) cycles minimum.
- Width rules:
  - The count is unsigned; the maximum 2^C-1 is supported.
  - The remaining counter is C bits and never underflows, because it only decrements while it is >0.
- Requests that arrive while busy wait, with rX_ready=0. Their inputs must stay stable until acceptance.

Optional Feature:
- Macro: REPEAT_SCHED_FIXED_PRIO_EN.
- Defined: when both requesters are valid, requester 0 always wins. The prio pointer is removed or ignored.
- Undefined (default): round-robin as described above.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Single request: r0 data=42, count=3, out_ready=1 -> r0_ready pulses once; gen_valid with gen_data=42 one cycle later; out_data=42 x3 with out_id=0; out_last only on the 3rd element; back to IDLE.
- Simultaneous requests after reset: r0 (7, count 2) and r1 (9, count 2) both valid -> r0 served first (7,7), then r1 (9,9, out_id=1). Then a second simultaneous pair -> r1 served first (round-robin). With REPEAT_SCHED_FIXED_PRIO_EN, r0 is first both times.
- Backpressure: r1 data=5, count=4, out_ready toggles 1,0,0,1,... -> exactly 4 transfers of 5; remaining holds while out_ready=0; gen_s_ready tracks out_ready.
- Zero count: r0 count=0 -> r0_ready pulses, no gen_valid, no out_valid; a pending r1 request is granted the next cycle.
- Reset mid-RUN: r0 count=10, assert rst after 3 elements -> all outputs 0 immediately; after deassert, r1 (count 1) is served normally with out_last=1.
- Maximum count: r0 count=255 -> exactly 255 elements; out_last only on element 255.
